// File: rtl/n64_vstream_gen.sv
// rtl/n64_vstream_gen.sv - synthetic N64 video-interface stream generator (color bars)
//
// Produces the 4-phase nVDSYNC cadence: phase 0 carries the sync nibble
// {3'b000, nVSYNC, nCLAMP, nHSYNC, nCSYNC}, and phases 1..3 carry 7-bit R, G, B.
// The NTSC/PAL and progressive/interlaced timing is latched at frame end, so the
// new mode applies from the next frame.
//
// Ports:
//   VCLK           in   video clock
//   nRST           in   asynchronous active-low reset
//   pal_mode_i     in   1 = PAL timing, 0 = NTSC timing
//   interlaced_i   in   1 = 480i/576i, 0 = 240p/288p
//   enable_i       in   1 = color bars, 0 = RGB forced to 0 (syncs unaffected)
//   nVDSYNC_o      out  low in the sync phase, one VCLK in four
//   D_o[6:0]       out  sync nibble or color word, by phase
//   field_o        out  current field (1 = vsync started mid-line)
//   frame_start_o  out  pulse in the phase-0 cycle of slot (0,0)
module n64_vstream_gen #(
  parameter int H_TOTAL_NTSC = 773,
  parameter int H_TOTAL_PAL  = 794,
  parameter int HSYNC_LEN    = 57,
  parameter int CLAMP_START  = 64,
  parameter int CLAMP_LEN    = 16,
  parameter int H_ACT_START  = 128,
  parameter int H_ACT_LEN    = 640,
  parameter int V_ACT_START  = 20,
  parameter int VSYNC_LINES  = 3
) (
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       pal_mode_i,
  input  logic       interlaced_i,
  input  logic       enable_i,
  output logic       nVDSYNC_o,
  output logic [6:0] D_o,
  output logic       field_o,
  output logic       frame_start_o
);

  localparam logic [9:0] HT_N    = 10'(H_TOTAL_NTSC);
  localparam logic [9:0] HT_P    = 10'(H_TOTAL_PAL);
  localparam logic [9:0] HS_LEN  = 10'(HSYNC_LEN);
  localparam logic [9:0] CL_S    = 10'(CLAMP_START);
  localparam logic [9:0] CL_E    = 10'(CLAMP_START + CLAMP_LEN);
  localparam logic [9:0] HA_S    = 10'(H_ACT_START);
  localparam logic [9:0] HA_E    = 10'(H_ACT_START + H_ACT_LEN);
  localparam logic [9:0] VA_S    = 10'(V_ACT_START);
  localparam logic [9:0] VS_LN   = 10'(VSYNC_LINES);

  // run_q holds off counting for one edge after reset release so that the
  // counters are "loaded" at (0,0,0) before the first output is registered.
  logic       run_q;
  logic [1:0] p_q;
  logic [9:0] h_q, l_q;
  logic [8:0] fl_q;
  logic       pal_q, int_q, field_q, en_q;
  logic [6:0] sub_q;
  logic [2:0] bar_q;

  logic [9:0] h_tot, l_tot, l_mid, h_mid, h_nxt, v_end;
  logic       h_last, l_last, slot_end;
  logic       vs_n, hs_n, cl_n, cs_n, vs1_win;
  logic       fall0, fall1, field_cur, active;
  logic [8:0] fl_cur;
  logic [6:0] r_w, g_w, b_w;

  always_comb begin
    h_tot = pal_q ? HT_P : HT_N;
    case ({pal_q, int_q})
      2'b00:   l_tot = 10'd263;
      2'b01:   l_tot = 10'd525;
      2'b10:   l_tot = 10'd313;
      default: l_tot = 10'd625;
    endcase
    l_mid    = (l_tot - 10'd1) >> 1;
    h_mid    = h_tot >> 1;
    h_last   = (h_q == h_tot - 10'd1);
    l_last   = (l_q == l_tot - 10'd1);
    slot_end = (p_q == 2'd3);
    h_nxt    = h_last ? 10'd0 : h_q + 10'd1;

    // Field-1 vsync spans VSYNC_LINES*H_TOTAL slots starting mid-line.
    vs1_win = int_q &&
              ((l_q == l_mid && h_q >= h_mid) ||
               (l_q > l_mid && l_q < l_mid + VS_LN) ||
               (l_q == l_mid + VS_LN && h_q < h_mid));
    vs_n = (l_q >= VS_LN) && !vs1_win;
    hs_n = (h_q >= HS_LEN);
    cl_n = !(h_q >= CL_S && h_q < CL_E);
    // Serration approximation: csync inverts hsync during vsync.
    cs_n = vs_n ? hs_n : !hs_n;

    fall0 = (l_q == 10'd0) && (h_q == 10'd0);
    fall1 = int_q && (l_q == l_mid) && (h_q == h_mid);

    // Field line of the current slot; fl_q holds the value of the previous slot.
    if (fall0 || fall1) begin
      fl_cur = 9'd0;
    end else if (h_q == 10'd0 && fl_q != 9'h1FF) begin
      fl_cur = fl_q + 9'd1;
    end else begin
      fl_cur = fl_q;
    end
    field_cur = fall0 ? 1'b0 : (fall1 ? 1'b1 : field_q);

    v_end  = VA_S + (pal_q ? 10'd288 : 10'd240);
    active = en_q && ({1'b0, fl_cur} >= VA_S) && ({1'b0, fl_cur} < v_end) &&
             (h_q >= HA_S) && (h_q < HA_E);
    r_w = (active && !bar_q[1]) ? 7'h7F : 7'h00;
    g_w = (active && !bar_q[2]) ? 7'h7F : 7'h00;
    b_w = (active && !bar_q[0]) ? 7'h7F : 7'h00;
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      run_q   <= 1'b0;
      p_q     <= 2'd0;
      h_q     <= 10'd0;
      l_q     <= 10'd0;
      fl_q    <= 9'd0;
      pal_q   <= 1'b0;
      int_q   <= 1'b0;
      field_q <= 1'b0;
      en_q    <= 1'b0;
      sub_q   <= 7'd0;
      bar_q   <= 3'd0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      p_q <= p_q + 2'd1;
      if (p_q == 2'd0) begin
        en_q <= enable_i;
      end
      if (slot_end) begin
        h_q     <= h_nxt;
        fl_q    <= fl_cur;
        field_q <= field_cur;
        // 80-slot bar subcounter, realigned at the first active slot.
        if (h_nxt == HA_S) begin
          sub_q <= 7'd0;
          bar_q <= 3'd0;
        end else if (sub_q == 7'd79) begin
          sub_q <= 7'd0;
          bar_q <= bar_q + 3'd1;
        end else begin
          sub_q <= sub_q + 7'd1;
        end
        if (h_last) begin
          if (l_last) begin
            l_q   <= 10'd0;
            pal_q <= pal_mode_i;
            int_q <= interlaced_i;
          end else begin
            l_q <= l_q + 10'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      nVDSYNC_o     <= 1'b1;
      D_o           <= 7'h0F;
      field_o       <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (run_q) begin
      nVDSYNC_o <= (p_q != 2'd0);
      case (p_q)
        2'd0:    D_o <= {3'b000, vs_n, cl_n, hs_n, cs_n};
        2'd1:    D_o <= r_w;
        2'd2:    D_o <= g_w;
        default: D_o <= b_w;
      endcase
      field_o       <= field_cur;
      frame_start_o <= (p_q == 2'd0) && fall0;
    end
  end

endmodule

// File: tb/tb_n64_vstream_gen.sv
// tb/tb_n64_vstream_gen.sv - self-checking bench for n64_vstream_gen
module tb_n64_vstream_gen;

  logic VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  // Instance A: default timing, used for reset, line and active-region vectors.
  logic       nrst_a, pal_a, int_a, en_a;
  logic       nvd_a, fld_a, fs_a;
  logic [6:0] d_a;
  // Instance B: shortened lines so whole frames and mode changes fit the run.
  logic       nrst_b, pal_b, int_b, en_b;
  logic       nvd_b, fld_b, fs_b;
  logic [6:0] d_b;

  n64_vstream_gen dut_a (
    .VCLK(VCLK), .nRST(nrst_a), .pal_mode_i(pal_a), .interlaced_i(int_a),
    .enable_i(en_a), .nVDSYNC_o(nvd_a), .D_o(d_a), .field_o(fld_a),
    .frame_start_o(fs_a)
  );

  n64_vstream_gen #(
    .H_TOTAL_NTSC(7), .H_TOTAL_PAL(9), .HSYNC_LEN(2), .CLAMP_START(3),
    .CLAMP_LEN(2), .H_ACT_START(5), .H_ACT_LEN(2), .V_ACT_START(20),
    .VSYNC_LINES(3)
  ) dut_b (
    .VCLK(VCLK), .nRST(nrst_b), .pal_mode_i(pal_b), .interlaced_i(int_b),
    .enable_i(en_b), .nVDSYNC_o(nvd_b), .D_o(d_b), .field_o(fld_b),
    .frame_start_o(fs_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base_a   = 0;
  always @(posedge VCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int         line;
    int         slot;
    logic       en;
    logic [6:0] d0, r, g, b;
  } vec_t;
  localparam int NV = 19;
  vec_t vecs [NV];

  // Per-frame mode expected on B: {pal, interlaced}.
  logic [1:0] fmode [6];

  function automatic int f_h(input logic [1:0] m);
    return m[1] ? 9 : 7;
  endfunction
  function automatic int f_l(input logic [1:0] m);
    case (m)
      2'b00:   return 263;
      2'b01:   return 525;
      2'b10:   return 313;
      default: return 625;
    endcase
  endfunction
  // Cycles from frame start to the field-1 vsync fall: NTSC (262,3), PAL (312,4).
  function automatic int f_f1(input logic [1:0] m);
    if (m == 2'b01) return (262 * 7 + 3) * 4;
    if (m == 2'b11) return (312 * 9 + 4) * 4;
    return 0;
  endfunction

  // ---------------- monitor A: phase cadence and line period ----------------
  logic a_mon = 1'b0;
  int   a_since_low = 0, a_since_hs = 0;
  bit   a_have_low = 0, a_have_hs = 0, a_hs_prev = 1;
  always @(negedge VCLK) begin
    if (a_mon) begin
      a_since_low++;
      a_since_hs++;
      if (!nvd_a) begin
        if (a_have_low) chk("a_vdsync_period", a_since_low, 4);
        a_have_low  = 1;
        a_since_low = 0;
        if (a_hs_prev && !d_a[1]) begin
          if (a_have_hs) chk("a_line_period", a_since_hs, 4 * 773);
          a_have_hs  = 1;
          a_since_hs = 0;
        end
        a_hs_prev = d_a[1];
      end
    end
  end

  // ---------------- monitor B: frame/field structure ----------------
  logic b_mon = 1'b0;
  int   b_frame = -1, b_since_fs = 0, b_since_hs = 0, b_since_low = 0;
  int   b_hcount = 0, b_vs_falls = 0, b_mid = 0;
  bit   b_have_low = 0, b_have_hs = 0, b_have_vs = 0, b_vs_pal = 0;
  bit   b_hs_prev = 1, b_vs_prev = 1, hs_fall, vs_fall;
  always @(negedge VCLK) begin
    if (b_mon) begin
      b_since_fs++;
      b_since_hs++;
      b_since_low++;
      if (fs_b) chk("b_fs_in_sync_phase", nvd_b, 0);
      if (!nvd_b) begin
        if (b_have_low) chk("b_vdsync_period", b_since_low, 4);
        b_have_low  = 1;
        b_since_low = 0;
        hs_fall = b_hs_prev && !d_b[1];
        vs_fall = b_vs_prev && !d_b[3];
        if (hs_fall) begin
          if (b_have_hs && b_frame >= 0) chk("b_line_period", b_since_hs, 4 * f_h(fmode[b_frame]));
          b_have_hs  = 1;
          b_since_hs = 0;
          if (!vs_fall) b_hcount++;
        end
        if (fs_b) begin
          if (b_frame >= 0)
            chk($sformatf("b_frame%0d_period", b_frame), b_since_fs,
                4 * f_h(fmode[b_frame]) * f_l(fmode[b_frame]));
          if (b_frame < 5) b_frame++;
          b_since_fs = 0;
        end
        if (vs_fall && b_frame >= 0) begin
          b_vs_falls++;
          if (fs_b) begin
            chk("b_f0_vs_with_hs", int'(hs_fall), 1);
            chk("b_f0_field", fld_b, 0);
          end else begin
            b_mid++;
            chk("b_f1_mode_interlaced", fmode[b_frame][0], 1);
            chk("b_f1_offset", b_since_fs, f_f1(fmode[b_frame]));
            chk("b_f1_hsync_high", d_b[1], 1);
            chk("b_f1_field", fld_b, 1);
          end
          if (b_have_vs) chk("b_hsyncs_per_field", b_hcount, b_vs_pal ? 312 : 262);
          b_have_vs = 1;
          b_vs_pal  = fmode[b_frame][1];
          b_hcount  = 0;
        end
        b_hs_prev = d_b[1];
        b_vs_prev = d_b[3];
      end
    end
  end

  // ---------------- sequences ----------------
  task automatic wait_a(input int k);
    while (cyc < base_a + k) @(negedge VCLK);
  endtask

  task automatic run_a();
    int s0;
    for (int i = 0; i < NV; i++) begin
      s0 = (vecs[i].line * 773 + vecs[i].slot) * 4;
      wait_a(s0 + 1);
      en_a = vecs[i].en;
      wait_a(s0 + 2);
      chk($sformatf("a_v%0d_nvdsync0", i), nvd_a, 0);
      chk($sformatf("a_v%0d_sync", i), d_a, vecs[i].d0);
      wait_a(s0 + 3);
      chk($sformatf("a_v%0d_nvdsync1", i), nvd_a, 1);
      chk($sformatf("a_v%0d_r", i), d_a, vecs[i].r);
      wait_a(s0 + 4);
      chk($sformatf("a_v%0d_g", i), d_a, vecs[i].g);
      wait_a(s0 + 5);
      chk($sformatf("a_v%0d_b", i), d_a, vecs[i].b);
    end
  endtask

  task automatic wait_b_frame(input int n, input int budget);
    int k = 0;
    while (b_frame < n && k < budget) begin
      @(negedge VCLK);
      k++;
    end
    if (b_frame < n) chk($sformatf("b_wait_frame%0d", n), b_frame, n);
  endtask

  task automatic run_b();
    int k;
    wait_b_frame(1, 20000);
    repeat (3000) @(negedge VCLK);
    int_b = 1'b1;                      // frame 1 stays 240p, frame 2 is 480i
    wait_b_frame(2, 20000);
    repeat (3000) @(negedge VCLK);
    pal_b = 1'b1;                      // frame 2 keeps NTSC, frame 3 is 576i
    wait_b_frame(3, 20000);
    repeat (3000) @(negedge VCLK);
    pal_b = 1'b0;
    int_b = 1'b0;
    wait_b_frame(5, 40000);
    chk("b_vs_falls_total", b_vs_falls, 8);
    chk("b_mid_line_falls", b_mid, 2);
    // Mid-line asynchronous reset, asserted right after a sync-phase output.
    repeat (101) @(negedge VCLK);
    k = 0;
    while (nvd_b && k < 8) begin
      @(negedge VCLK);
      k++;
    end
    chk("b_pre_reset_sync_phase", nvd_b, 0);
    b_mon = 1'b0;
    #1 nrst_b = 1'b0;
    #1;
    chk("b_async_rst_nvdsync", nvd_b, 1);
    chk("b_async_rst_d", d_b, 7'h0F);
    chk("b_async_rst_fs", fs_b, 0);
    repeat (3) @(negedge VCLK);
    nrst_b = 1'b1;
    @(negedge VCLK);
    chk("b_restart_edge1_d", d_b, 7'h0F);
    @(negedge VCLK);
    chk("b_restart_nvdsync", nvd_b, 0);
    chk("b_restart_d", d_b, 7'h05);
    chk("b_restart_fs", fs_b, 1);
    chk("b_restart_field", fld_b, 0);
  endtask

  initial begin
    nrst_a = 1'b0; pal_a = 1'b0; int_a = 1'b0; en_a = 1'b1;
    nrst_b = 1'b0; pal_b = 1'b0; int_b = 1'b0; en_b = 1'b1;
    fmode[0] = 2'b00; fmode[1] = 2'b00; fmode[2] = 2'b01;
    fmode[3] = 2'b11; fmode[4] = 2'b00; fmode[5] = 2'b00;
    //         line slot en    d0     r      g      b
    vecs[0]  = '{19, 128, 1'b1, 7'h0F, 7'h00, 7'h00, 7'h00};
    vecs[1]  = '{20,   0, 1'b1, 7'h0C, 7'h00, 7'h00, 7'h00};
    vecs[2]  = '{20,  64, 1'b1, 7'h0B, 7'h00, 7'h00, 7'h00};
    vecs[3]  = '{20, 127, 1'b1, 7'h0F, 7'h00, 7'h00, 7'h00};
    vecs[4]  = '{20, 128, 1'b1, 7'h0F, 7'h7F, 7'h7F, 7'h7F};
    vecs[5]  = '{20, 207, 1'b1, 7'h0F, 7'h7F, 7'h7F, 7'h7F};
    vecs[6]  = '{20, 208, 1'b1, 7'h0F, 7'h7F, 7'h7F, 7'h00};
    vecs[7]  = '{20, 288, 1'b1, 7'h0F, 7'h00, 7'h7F, 7'h7F};
    vecs[8]  = '{20, 368, 1'b1, 7'h0F, 7'h00, 7'h7F, 7'h00};
    vecs[9]  = '{20, 448, 1'b1, 7'h0F, 7'h7F, 7'h00, 7'h7F};
    vecs[10] = '{20, 528, 1'b1, 7'h0F, 7'h7F, 7'h00, 7'h00};
    vecs[11] = '{20, 608, 1'b1, 7'h0F, 7'h00, 7'h00, 7'h7F};
    vecs[12] = '{20, 687, 1'b1, 7'h0F, 7'h00, 7'h00, 7'h7F};
    vecs[13] = '{20, 688, 1'b1, 7'h0F, 7'h00, 7'h00, 7'h00};
    vecs[14] = '{20, 768, 1'b1, 7'h0F, 7'h00, 7'h00, 7'h00};
    vecs[15] = '{20, 772, 1'b1, 7'h0F, 7'h00, 7'h00, 7'h00};
    vecs[16] = '{21,   0, 1'b0, 7'h0C, 7'h00, 7'h00, 7'h00};
    vecs[17] = '{21, 128, 1'b0, 7'h0F, 7'h00, 7'h00, 7'h00};
    vecs[18] = '{21, 250, 1'b0, 7'h0F, 7'h00, 7'h00, 7'h00};

    repeat (3) @(negedge VCLK);
    chk("a_rst_nvdsync", nvd_a, 1);
    chk("a_rst_d", d_a, 7'h0F);
    chk("a_rst_field", fld_a, 0);
    chk("a_rst_fs", fs_a, 0);
    @(negedge VCLK);
    nrst_a = 1'b1;
    nrst_b = 1'b1;
    base_a = cyc;
    a_mon  = 1'b1;
    b_mon  = 1'b1;
    wait_a(1);
    chk("a_edge1_nvdsync", nvd_a, 1);
    chk("a_edge1_d", d_a, 7'h0F);
    wait_a(2);
    // Slot (0,0): vsync and hsync low, clamp inactive, csync inverted during vsync.
    chk("a_first_nvdsync", nvd_a, 0);
    chk("a_first_d", d_a, 7'h05);
    chk("a_first_fs", fs_a, 1);
    wait_a(3);
    chk("a_fs_one_cycle", fs_a, 0);
    chk("a_first_r", d_a, 7'h00);
    fork
      run_a();
      run_b();
    join
    chk("a_field_progressive", fld_a, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
